// File: rtl/cnn_pkg.sv
// Shared constants and types for the OFM packing path: memory geometry,
// activation width and saturation limits, and the packer FSM encoding.
package cnn_pkg;

    localparam int ADDR_W  = 10;
    localparam int MEM_DW  = 32;
    localparam int ACT_W   = 8;
    localparam int ACT_MIN = -128;
    localparam int ACT_MAX = 127;
    localparam int LANES   = MEM_DW / ACT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ofm_packer_if.sv
// PE-result handshake and memory write bus of the OFM packer.
// master = packer side, slave = PE array / memory side.
interface ofm_packer_if #(
    parameter int PSUM_W = 16,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) ();
    import cnn_pkg::*;

    logic              psum_valid;
    logic [PSUM_W-1:0] psum_data;
    logic              psum_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;

    modport master (
        input  psum_valid, psum_data,
        output psum_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output psum_valid, psum_data,
        input  psum_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ofm_quant.sv
// Combinational requantiser: arithmetic shift then clamp to an 8-bit activation.
// OFM_RELU_EN narrows the clamp range to [0, 127].
module ofm_quant
    import cnn_pkg::*;
#(
    parameter int PSUM_W = 16,
    parameter int QSHIFT = 4
) (
    input  logic signed [PSUM_W-1:0] psum,
    output logic        [ACT_W-1:0]  q
);

    localparam logic signed [PSUM_W-1:0] HI = PSUM_W'(ACT_MAX);
    localparam logic signed [PSUM_W-1:0] LO = PSUM_W'(ACT_MIN);

    logic signed [PSUM_W-1:0] sh;

    assign sh = psum >>> QSHIFT;

    always_comb begin
        q = sh[ACT_W-1:0];
`ifdef OFM_RELU_EN
        if (sh[PSUM_W-1])
            q = '0;
        else if (sh > HI)
            q = HI[ACT_W-1:0];
`else
        if (sh > HI)
            q = HI[ACT_W-1:0];
        else if (sh < LO)
            q = LO[ACT_W-1:0];
`endif
    end

endmodule

// File: rtl/ofm_packer.sv
// Packs four requantised PE results per 32-bit word and writes them to
// consecutive memory words from a latched base. OFM_RELU_EN selects ReLU clamping.
module ofm_packer #(
    parameter int PSUM_W = 16,
    parameter int QSHIFT = 4,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        word_count,
    output logic              busy,
    output logic              done,
    ofm_packer_if.master      bus
);
    import cnn_pkg::*;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  base_q;
    logic [7:0]         count_q;
    logic [7:0]         idx;
    logic [8:0]         idx_inc;
    logic [1:0]         lane;
    logic [MEM_DW-1:0]  pack;
    logic [ACT_W-1:0]   q;
    logic               fire;

    ofm_quant #(
        .PSUM_W (PSUM_W),
        .QSHIFT (QSHIFT)
    ) u_quant (
        .psum (bus.psum_data),
        .q    (q)
    );

    assign fire    = bus.psum_valid & bus.psum_ready;
    assign idx_inc = {1'b0, idx} + 9'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (word_count == 8'd0) ? S_DONE : S_PACK;
            S_PACK:  if (fire && lane == 2'd3) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (idx_inc == {1'b0, count_q}) ? S_DONE : S_PACK;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.psum_ready = (state == S_PACK);
        bus.mem_we     = (state == S_WRITE);
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);
    end

    // Address and data are registered on the fourth transfer so they are
    // stable through WRITE and hold afterwards until the next word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q        <= '0;
            count_q       <= '0;
            idx           <= '0;
            lane          <= '0;
            pack          <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                base_q  <= base_addr;
                count_q <= word_count;
                idx     <= '0;
                lane    <= '0;
            end
            if (fire) begin
                pack[{lane, 3'b000} +: ACT_W] <= q;
                lane <= lane + 2'd1;
                if (lane == 2'd3) begin
                    bus.mem_addr  <= base_q + ADDR_W'(idx);
                    bus.mem_wdata <= {q, pack[MEM_DW-ACT_W-1:0]};
                end
            end
            if (state == S_WRITE) begin
                idx  <= idx_inc[7:0];
                lane <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ofm_packer.sv
// Directed bench for ofm_packer: stimulus pushes expected memory writes into a
// scoreboard queue, a negedge monitor pops and checks every mem_we.
module tb_ofm_packer;
    import cnn_pkg::*;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

`ifdef OFM_RELU_EN
    localparam logic [31:0] SAT_W = 32'h0000007F;
    localparam logic [31:0] WRAP2 = 32'h00000605;
`else
    localparam logic [31:0] SAT_W = 32'h00FF807F;
    localparam logic [31:0] WRAP2 = 32'hFDFE0605;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [7:0]  word_count = '0;
    logic        busy, done;
    int          total = 0;
    int          bad = 0;
    int          lat;
    wr_t         exp_q[$];
    wr_t         e;
    logic [15:0] pv[8];

    ofm_packer_if #(.PSUM_W(16), .ADDR_W(10)) bus ();

    ofm_packer #(.PSUM_W(16), .QSHIFT(4), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            chk("ready_in_write", 32'(bus.psum_ready), 32'd0);
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("wr_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic do_start(input logic [9:0] b, input logic [7:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers pv[first..first+n-1]; with tog, valid is dropped on odd cycles.
    task automatic feed(input int first, input int n, input bit tog);
        int i = 0;
        int cyc = 0;
        bit vld, acc;
        while (i < n && cyc < 200) begin
            vld = !(tog && (cyc % 2) == 1);
            bus.psum_valid = vld;
            bus.psum_data  = pv[first + i];
            acc = vld && bus.psum_ready;
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        bus.psum_valid = 1'b0;
        chk("feed_count", i, n);
    endtask

    // we_gap < 0 means the job must finish without any write.
    task automatic wait_done(input string tag, input int we_gap, output int k);
        int we_at = -1;
        bit seen = 1'b0;
        k = 0;
        while (k < 30 && !seen) begin
            if (bus.mem_we) we_at = k;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (we_gap >= 0) chk({tag, "_done_gap"}, k - we_at, we_gap);
        else             chk({tag, "_no_we"}, we_at, -1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
    endtask

    initial begin
        bus.psum_valid = 1'b0;
        bus.psum_data  = '0;

        @(negedge clk);
        chk("rst_ready", 32'(bus.psum_ready), 32'd0);
        chk("rst_we",    32'(bus.mem_we),     32'd0);
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_done",  32'(done),           32'd0);
        chk("rst_addr",  32'(bus.mem_addr),   32'd0);
        chk("rst_data",  bus.mem_wdata,       32'd0);
        rst = 1'b1;
        @(negedge clk);

        // basic job
        for (int j = 0; j < 8; j++) pv[j] = 16'(16 * (j + 1));
        exp_q.push_back('{10'h010, 32'h04030201});
        do_start(10'h010, 8'd1);
        feed(0, 4, 1'b0);
        wait_done("basic", 1, lat);

        // saturation
        pv[0] = 16'h7FFF; pv[1] = 16'h8000; pv[2] = 16'hFFF0; pv[3] = 16'h0000;
        exp_q.push_back('{10'h020, SAT_W});
        do_start(10'h020, 8'd1);
        feed(0, 4, 1'b0);
        wait_done("sat", 1, lat);

        // address wrap with valid toggling
        for (int j = 0; j < 6; j++) pv[j] = 16'(16 * (j + 1));
        pv[6] = 16'hFFE0; pv[7] = 16'hFFD0;
        exp_q.push_back('{10'h3FF, 32'h04030201});
        exp_q.push_back('{10'h000, WRAP2});
        do_start(10'h3FF, 8'd2);
        feed(0, 8, 1'b1);
        wait_done("wrap", 1, lat);
        chk("hold_addr", 32'(bus.mem_addr), 32'h000);
        chk("hold_data", bus.mem_wdata, WRAP2);

        // zero count
        do_start(10'h123, 8'd0);
        wait_done("zero", -1, lat);
        chk("zero_lat_ok", 32'(lat <= 1), 32'd1);

        // start during PACK is ignored
        pv[0] = 16'h0050; pv[1] = 16'h0060; pv[2] = 16'h0070; pv[3] = 16'h0080;
        exp_q.push_back('{10'h040, 32'h08070605});
        do_start(10'h040, 8'd1);
        feed(0, 2, 1'b0);
        chk("busy_mid", 32'(busy), 32'd1);
        do_start(10'h200, 8'd5);
        feed(2, 2, 1'b0);
        wait_done("busystart", 1, lat);

        // reset mid-job
        pv[0] = 16'h0100; pv[1] = 16'h0200; pv[2] = 16'h0300; pv[3] = 16'h0400;
        do_start(10'h050, 8'd1);
        feed(0, 2, 1'b0);
        rst = 1'b0;
        #1;
        chk("mrst_busy",  32'(busy),           32'd0);
        chk("mrst_ready", 32'(bus.psum_ready), 32'd0);
        chk("mrst_we",    32'(bus.mem_we),     32'd0);
        chk("mrst_done",  32'(done),           32'd0);
        chk("mrst_addr",  32'(bus.mem_addr),   32'd0);
        chk("mrst_data",  bus.mem_wdata,       32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        exp_q.push_back('{10'h060, 32'h40302010});
        do_start(10'h060, 8'd1);
        feed(0, 4, 1'b0);
        wait_done("post_rst", 1, lat);

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
